// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: strobes columns, synchronises rows, debounces whole frames and
// hands a single accepted key to the consumer through a 1-deep valid/ready register.
module keypad_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HEX_MAP  = 1,
    parameter int unsigned KEY_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row_n,
    output logic [COLS-1:0]  col_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             multi_key,
    output logic             overflow
);

    localparam int unsigned IDX_W = $clog2(ROWS * COLS);
    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    localparam logic [COLS-1:0] COL_ONE = COLS'(1);
    // Nibble n holds the legend of index n (row-major over a 4x4 pad).
    localparam logic [63:0]     HEX_LUT = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {StIdle, StCand, StPressed, StRel} state_t;

    logic [ROWS-1:0]  r_row_s1, r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [CW-1:0]    r_col;
    logic [COLS-1:0]  r_col_n;
    logic [1:0]       r_fcnt;
    logic [RW-1:0]    r_frow;
    logic [CW-1:0]    r_fcol;
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_cand, r_acc;
    logic             r_emit;
    logic [KEY_W-1:0] r_emit_code;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid, r_key_held, r_multi, r_overflow;

    logic             w_tick, w_frame_end, w_single, w_acc_present, w_last_col;
    logic [CW-1:0]    w_col_next;
    logic [ROWS-1:0]  w_hit;
    logic [1:0]       w_colcnt, w_tot;
    logic [2:0]       w_sum;
    logic [RW-1:0]    w_col_row, w_krow;
    logic [CW-1:0]    w_kcol;
    logic [IDX_W-1:0] w_idx;

    function automatic logic [KEY_W-1:0] f_encode(input logic [IDX_W-1:0] idx);
        logic [3:0] sel;
        logic [3:0] v;
        sel = 4'(idx);
        v   = HEX_LUT[{sel, 2'b00} +: 4];
        return (HEX_MAP != 0) ? KEY_W'(v) : KEY_W'(idx);
    endfunction

    assign w_tick      = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_last_col  = (r_col == CW'(COLS - 1));
    assign w_frame_end = w_tick && w_last_col;
    assign w_col_next  = w_last_col ? '0 : r_col + CW'(1);

    // Fold the current column into the frame tally; saturates at 2 (= MULTI).
    always_comb begin
        w_hit     = ~r_row_s2;
        w_colcnt  = 2'd0;
        w_col_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_col_row = RW'(i);
                if (w_colcnt != 2'd2) w_colcnt = w_colcnt + 2'd1;
            end
        end
        w_sum = {1'b0, r_fcnt} + {1'b0, w_colcnt};
        w_tot = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        if (r_fcnt == 2'd0 && w_colcnt == 2'd1) begin
            w_krow = w_col_row;
            w_kcol = r_col;
        end else begin
            w_krow = r_frow;
            w_kcol = r_fcol;
        end
        w_idx = IDX_W'(w_krow) * IDX_W'(COLS) + IDX_W'(w_kcol);
    end

    assign w_single      = (w_tot == 2'd1);
    assign w_acc_present = w_single && (w_idx == r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_s1 <= '0;
            r_row_s2 <= '0;
            r_div    <= '0;
            r_col    <= '0;
            r_col_n  <= ~COL_ONE;
            r_fcnt   <= 2'd0;
            r_frow   <= '0;
            r_fcol   <= '0;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
            if (w_tick) begin
                r_div   <= '0;
                r_col   <= w_col_next;
                r_col_n <= ~(COL_ONE << w_col_next);
                if (w_frame_end) begin
                    r_fcnt <= 2'd0;
                    r_frow <= '0;
                    r_fcol <= '0;
                end else begin
                    r_fcnt <= w_tot;
                    r_frow <= w_krow;
                    r_fcol <= w_kcol;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_cand      <= '0;
            r_acc       <= '0;
            r_emit      <= 1'b0;
            r_emit_code <= '0;
            r_key_held  <= 1'b0;
            r_multi     <= 1'b0;
        end else begin
            r_emit <= 1'b0;
            if (w_frame_end) begin
                r_multi <= (w_tot == 2'd2);
                unique case (r_state)
                    StIdle: begin
                        if (w_single) begin
                            if (DEBOUNCE <= 1) begin
                                r_state     <= StPressed;
                                r_acc       <= w_idx;
                                r_emit      <= 1'b1;
                                r_emit_code <= f_encode(w_idx);
                                r_key_held  <= 1'b1;
                            end else begin
                                r_state <= StCand;
                                r_cand  <= w_idx;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    StCand: begin
                        if (!w_single) begin
                            r_state <= StIdle;
                        end else if (w_idx != r_cand) begin
                            r_cand <= w_idx;
                            r_cnt  <= 4'd1;
                        end else if ((r_cnt + 4'd1) >= 4'(DEBOUNCE)) begin
                            r_state     <= StPressed;
                            r_acc       <= w_idx;
                            r_emit      <= 1'b1;
                            r_emit_code <= f_encode(w_idx);
                            r_key_held  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    StPressed: begin
                        if (!w_acc_present) begin
                            if (DEBOUNCE <= 1) begin
                                r_state    <= StIdle;
                                r_key_held <= 1'b0;
                            end else begin
                                r_state <= StRel;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    StRel: begin
                        if (w_acc_present) begin
                            r_state <= StPressed;
                        end else if ((r_cnt + 4'd1) >= 4'(DEBOUNCE)) begin
                            r_state    <= StIdle;
                            r_key_held <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    // Holding register: a new event beats a same-cycle accept; a full register drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_emit && (!r_key_valid || key_ready)) begin
                r_key_code  <= r_emit_code;
                r_key_valid <= 1'b1;
            end else begin
                if (r_emit) r_overflow <= 1'b1;
                if (r_key_valid && key_ready) r_key_valid <= 1'b0;
            end
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_key = r_multi;
    assign overflow  = r_overflow;

endmodule
